npu_layer_sequencer: RTL and testbench
======================================

Name: npu_layer_sequencer

Overview:
- Autonomous controller that runs one full inference without per-step host commands: conv1 pass, CHAN accumulated conv2 passes, then the FC1 weight-group stream and the FC2 finish.
- Drives the conv engine's trigger/clear/layer controls, the partial-sum save/clear strobes and the fcn start/next strobes.
- Requests each weight set from the host/DMA side through a req/ack handshake.
- Sits between the host register decode and the conv / partial_sum / fcn datapath, replacing the host-stepped control FSM.

Parameters:
- CHAN, 10, number of conv2 accumulation passes.
- CONV1_LAST, 182, conv_addr value that ends a conv1 pass.
- CONV2_LAST, 132, conv_addr value that ends a conv2 pass.
- FC1_GROUPS, 330, FC1 weight groups (NUM_PE weights each) per inference.
- TIMEOUT_CYC, 4096, watchdog limit in cycles; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begins an inference when idle.
- abort  in  1  synchronous abort; returns the block to IDLE.
- conv_addr  in  8  current conv output pixel address.
- conv_pixel_valid  in  1  conv engine output pixel valid.
- conv_trigger  out  1  1-cycle pulse; starts a conv pass.
- conv_clear  out  1  1-cycle pulse; clears the conv address counter.
- conv_layer  out  1  0 = conv1, 1 = conv2 (partial-sum enable).
- psum_save  out  1  accumulate the current pixel into partial_sum.
- psum_clear  out  1  1-cycle pulse; zeroes partial_sum.
- w_req  out  1  weight load request, level.
- w_ack  in  1  weight set loaded.
- w_kind  out  2  0 = conv1, 1 = conv2 channel, 2 = fc1 group.
- w_idx  out  9  channel or group index of the request.
- fc_start  out  1  1-cycle pulse; first FC1 group.
- fc_next  out  1  1-cycle pulse; subsequent FC1 groups.
- fc_valid  in  1  fcn consumed the current group.
- fc_done  in  1  fcn logit ready.
- busy  out  1  high from the cycle after start until DONE/ERR/IDLE.
- done  out  1  1-cycle pulse on completion.
- err  out  1  sticky; cleared by the next accepted start or by reset.
- state_o  out  4  current state encoding, for the status register.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-operation aborts immediately with no drain.
- States: IDLE, C1_WLOAD, C1_RUN, C1_DRAIN, C2_WLOAD, C2_RUN, C2_DRAIN, FC_WLOAD, FC_RUN, FC_FINISH, DONE, ERR.
- IDLE:
  - start -> C1_WLOAD.
  - Same cycle: chan_cnt = 0, grp_cnt = 0, err cleared, psum_clear pulsed the next cycle.
  - start while not IDLE/DONE/ERR is ignored.
- *_WLOAD:
  - w_req = 1 with w_kind/w_idx stable; held until w_ack is sampled high.
  - On the w_ack cycle: w_req drops next cycle and the state advances.
  - w_ack outside WLOAD is ignored.
  - w_ack held high continuously gives a 1-cycle request.
- C1_RUN:
  - conv_layer = 0; conv_trigger pulsed on the first cycle in state.
  - conv_addr == CONV1_LAST -> C1_DRAIN.
- C1_DRAIN: conv_clear pulsed for 1 cycle -> C2_WLOAD (w_kind = 1, w_idx = chan_cnt).
- C2_RUN:
  - conv_layer = 1; conv_trigger pulsed on entry.
  - psum_save = conv_pixel_valid AND (state == C2_RUN), combinational, zero latency.
  - conv_addr == CONV2_LAST -> C2_DRAIN.
- C2_DRAIN:
  - conv_clear pulsed; chan_cnt increments.
  - If chan_cnt == CHAN-1 before the increment -> FC_WLOAD (w_kind = 2, w_idx = grp_cnt); else -> C2_WLOAD.
  - conv_layer returns to 0 when leaving C2 states.
- FC_WLOAD: on ack, pulse fc_start if grp_cnt == 0, else fc_next -> FC_RUN.
- FC_RUN: fc_valid -> grp_cnt increments; if grp_cnt == FC1_GROUPS-1 before the increment -> FC_FINISH, else -> FC_WLOAD.
- FC_FINISH: fc_done -> DONE. fc_done in any other state is ignored.
- DONE: done pulse for 1 cycle, busy = 0 -> IDLE. A start arriving in DONE is accepted.
- abort (any non-IDLE state):
  - Next state IDLE; conv_clear pulsed; w_req and conv_layer drop next cycle; busy = 0.
  - No done pulse.
  - abort has priority over every simultaneous event; abort in IDLE has no effect.
- Simultaneous conv_addr end-match and conv_pixel_valid in C2_RUN: that pixel is still saved.
- Counters saturate at their final value; there is no wrap inside a run.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on every state change and increments otherwise in every state except IDLE/DONE/ERR.
  - Reaching TIMEOUT_CYC -> ERR: err = 1 sticky, busy = 0, w_req = 0, conv_clear pulsed.
  - ERR -> C1_WLOAD on start only.
- Not defined: no counter, no ERR entry; states wait indefinitely; err is tied to 0.

Test Plan:
- CHAN=2, FC1_GROUPS=3, CONV1_LAST=5, CONV2_LAST=4, w_ack 3 cycles after each w_req -> per run:
  - 1 conv1 trigger and 2 conv2 triggers.
  - 6 w_req handshakes with (kind, idx) = (0,0), (1,0), (1,1), (2,0), (2,1), (2,2).
  - 1 fc_start and 2 fc_next.
  - done pulse 1 cycle after fc_done.
- C2_RUN with conv_pixel_valid high on 4 cycles per pass -> psum_save count = 8; psum_save = 0 on all conv1 pixels.
- start pulsed again during C2_RUN -> ignored: counters unchanged, psum_clear not re-pulsed.
- abort asserted in FC_RUN -> next cycle state_o = IDLE, busy = 0, conv_clear = 1 for 1 cycle, no done; a new start then runs cleanly.
- SEQ_TIMEOUT_EN defined, TIMEOUT_CYC=16, w_ack never asserted -> err = 1 and state ERR after 16 cycles in C1_WLOAD. Not defined -> still in C1_WLOAD with w_req = 1 after 100 cycles.
- rst_ni low asynchronously mid FC_RUN -> all outputs 0 before the next clk edge; state_o = IDLE after release.

Source files
------------

// File: rtl/npu_layer_sequencer.sv
// npu_layer_sequencer: autonomous inference controller.
// Runs one conv1 pass, CHAN accumulated conv2 passes, FC1_GROUPS FC1 weight
// groups and the FC2 finish.
// Each weight set is fetched through a w_req/w_ack handshake before its pass.
// Optional feature: define SEQ_TIMEOUT_EN to enable the per-state watchdog
// and the ERR state. Without it, err is tied low and states wait forever.
module npu_layer_sequencer #(
  parameter int CHAN        = 10,
  parameter int CONV1_LAST  = 182,
  parameter int CONV2_LAST  = 132,
  parameter int FC1_GROUPS  = 330,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] conv_addr,
  input  logic       conv_pixel_valid,
  output logic       conv_trigger,
  output logic       conv_clear,
  output logic       conv_layer,
  output logic       psum_save,
  output logic       psum_clear,
  output logic       w_req,
  input  logic       w_ack,
  output logic [1:0] w_kind,
  output logic [8:0] w_idx,
  output logic       fc_start,
  output logic       fc_next,
  input  logic       fc_valid,
  input  logic       fc_done,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    C1_WLOAD  = 4'd1,
    C1_RUN    = 4'd2,
    C1_DRAIN  = 4'd3,
    C2_WLOAD  = 4'd4,
    C2_RUN    = 4'd5,
    C2_DRAIN  = 4'd6,
    FC_WLOAD  = 4'd7,
    FC_RUN    = 4'd8,
    FC_FINISH = 4'd9,
    DONE      = 4'd10,
    ERR       = 4'd11
  } state_t;

  localparam logic [7:0] C1_END   = 8'(CONV1_LAST);
  localparam logic [7:0] C2_END   = 8'(CONV2_LAST);
  localparam logic [8:0] CHAN_END = 9'(CHAN - 1);
  localparam logic [8:0] GRP_END  = 9'(FC1_GROUPS - 1);

  state_t     state;
  logic [8:0] chan_cnt;
  logic [8:0] grp_cnt;
  logic       wd_hit;

  assign state_o   = state;
  // Pixel accumulation is combinational so the save lines up with the pixel.
  assign psum_save = conv_pixel_valid && (state == C2_RUN);

`ifdef SEQ_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt;
  state_t          wd_state;
  logic            wd_counting;
  logic            err_r;

  assign wd_counting = !(state inside {IDLE, DONE, ERR});
  // wd_cnt holds the number of completed cycles spent in wd_state.
  assign wd_hit      = wd_counting && (state == wd_state) && (wd_cnt == WD_LAST);
  assign err         = err_r;

  // Watchdog: restarts on every state change, saturates otherwise.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt   <= '0;
      wd_state <= IDLE;
    end else begin
      wd_state <= state;
      if (!wd_counting)
        wd_cnt <= '0;
      else if (state != wd_state)
        wd_cnt <= WD_W'(1);
      else if (wd_cnt != {WD_W{1'b1}})
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // Main sequencer FSM; every strobe is registered and set on the transition
  // so it is high during the first cycle of the new state.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      chan_cnt     <= '0;
      grp_cnt      <= '0;
      conv_trigger <= 1'b0;
      conv_clear   <= 1'b0;
      conv_layer   <= 1'b0;
      psum_clear   <= 1'b0;
      w_req        <= 1'b0;
      w_kind       <= '0;
      w_idx        <= '0;
      fc_start     <= 1'b0;
      fc_next      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      err_r        <= 1'b0;
`endif
    end else begin
      conv_trigger <= 1'b0;
      conv_clear   <= 1'b0;
      psum_clear   <= 1'b0;
      fc_start     <= 1'b0;
      fc_next      <= 1'b0;
      done         <= 1'b0;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        conv_clear <= 1'b1;
        conv_layer <= 1'b0;
        w_req      <= 1'b0;
        busy       <= 1'b0;
      end else if (wd_hit) begin
        state      <= ERR;
        conv_clear <= 1'b1;
        conv_layer <= 1'b0;
        w_req      <= 1'b0;
        busy       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
        err_r      <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE, DONE, ERR: begin
            if (start) begin
              state      <= C1_WLOAD;
              chan_cnt   <= '0;
              grp_cnt    <= '0;
              psum_clear <= 1'b1;
              busy       <= 1'b1;
              conv_layer <= 1'b0;
              w_req      <= 1'b1;
              w_kind     <= 2'd0;
              w_idx      <= '0;
`ifdef SEQ_TIMEOUT_EN
              err_r      <= 1'b0;
`endif
            end else if (state == DONE) begin
              state <= IDLE;
            end
          end
          C1_WLOAD: if (w_ack) begin
            w_req        <= 1'b0;
            conv_trigger <= 1'b1;
            state        <= C1_RUN;
          end
          C1_RUN: if (conv_addr == C1_END) begin
            conv_clear <= 1'b1;
            state      <= C1_DRAIN;
          end
          C1_DRAIN: begin
            w_req  <= 1'b1;
            w_kind <= 2'd1;
            w_idx  <= chan_cnt;
            state  <= C2_WLOAD;
          end
          C2_WLOAD: if (w_ack) begin
            w_req        <= 1'b0;
            conv_trigger <= 1'b1;
            conv_layer   <= 1'b1;
            state        <= C2_RUN;
          end
          C2_RUN: if (conv_addr == C2_END) begin
            conv_clear <= 1'b1;
            state      <= C2_DRAIN;
          end
          C2_DRAIN: begin
            w_req <= 1'b1;
            if (chan_cnt == CHAN_END) begin
              // Last channel: counter stays saturated, hand over to FC1.
              conv_layer <= 1'b0;
              w_kind     <= 2'd2;
              w_idx      <= grp_cnt;
              state      <= FC_WLOAD;
            end else begin
              chan_cnt <= chan_cnt + 9'd1;
              w_kind   <= 2'd1;
              w_idx    <= chan_cnt + 9'd1;
              state    <= C2_WLOAD;
            end
          end
          FC_WLOAD: if (w_ack) begin
            w_req <= 1'b0;
            if (grp_cnt == '0)
              fc_start <= 1'b1;
            else
              fc_next  <= 1'b1;
            state <= FC_RUN;
          end
          FC_RUN: if (fc_valid) begin
            if (grp_cnt == GRP_END) begin
              state <= FC_FINISH;
            end else begin
              grp_cnt <= grp_cnt + 9'd1;
              w_req   <= 1'b1;
              w_kind  <= 2'd2;
              w_idx   <= grp_cnt + 9'd1;
              state   <= FC_WLOAD;
            end
          end
          FC_FINISH: if (fc_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Self-checking bench for npu_layer_sequencer with a small configuration
// (CHAN=2, FC1_GROUPS=3, CONV1_LAST=5, CONV2_LAST=4, TIMEOUT_CYC=16).
// Expected weight requests are queued when a run is started and popped as
// the sequencer raises each w_req.
module tb_npu_layer_sequencer;
  localparam int CHAN = 2, FC1_GROUPS = 3, CONV1_LAST = 5, CONV2_LAST = 4;
  localparam int TIMEOUT_CYC = 16;

  logic       clk = 1'b0, rst_ni = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] conv_addr = '0;
  logic       conv_pixel_valid = 1'b0, w_ack = 1'b0, fc_valid = 1'b0, fc_done = 1'b0;
  logic       conv_trigger, conv_clear, conv_layer, psum_save, psum_clear;
  logic       w_req, fc_start, fc_next, busy, done, err;
  logic [1:0] w_kind;
  logic [8:0] w_idx;
  logic [3:0] state_o;

  npu_layer_sequencer #(
    .CHAN(CHAN), .CONV1_LAST(CONV1_LAST), .CONV2_LAST(CONV2_LAST),
    .FC1_GROUPS(FC1_GROUPS), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_ni(rst_ni), .start(start), .abort(abort),
    .conv_addr(conv_addr), .conv_pixel_valid(conv_pixel_valid),
    .conv_trigger(conv_trigger), .conv_clear(conv_clear), .conv_layer(conv_layer),
    .psum_save(psum_save), .psum_clear(psum_clear),
    .w_req(w_req), .w_ack(w_ack), .w_kind(w_kind), .w_idx(w_idx),
    .fc_start(fc_start), .fc_next(fc_next), .fc_valid(fc_valid), .fc_done(fc_done),
    .busy(busy), .done(done), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_trig = 0, n_trig_c2 = 0, n_save = 0, n_pclr = 0, n_fcs = 0, n_fcn = 0, n_done = 0;
  logic [10:0] exp_q[$];

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (conv_trigger) n_trig++;
    if (conv_trigger && conv_layer) n_trig_c2++;
    if (psum_save) n_save++;
    if (psum_clear) n_pclr++;
    if (fc_start) n_fcs++;
    if (fc_next) n_fcn++;
    if (done) n_done++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] all_outs();
    return {conv_trigger, conv_clear, conv_layer, psum_save, psum_clear, w_req,
            w_kind, w_idx, fc_start, fc_next, busy, done, err, state_o};
  endfunction

  task automatic push_run;
    exp_q.push_back({2'd0, 9'd0});
    for (int c = 0; c < CHAN; c++) exp_q.push_back({2'd1, 9'(c)});
    for (int g = 0; g < FC1_GROUPS; g++) exp_q.push_back({2'd2, 9'(g)});
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Wait for a request, score it, then ack 3 cycles later.
  task automatic wload;
    int n;
    logic [10:0] e;
    n = 0;
    while (!w_req && n < 50) begin
      tick;
      n++;
    end
    chk("wreq_seen", w_req, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
    chk("w_kind", w_kind, e[10:9]);
    chk("w_idx", w_idx, e[8:0]);
    repeat (3) tick;
    chk("wreq_hold", w_req, 1);
    w_ack = 1'b1;
    tick;
    w_ack = 1'b0;
    chk("wreq_drop", w_req, 0);
  endtask

  task automatic conv_pass(input int last, input int first_valid, input bit poke_start);
    for (int a = 0; a <= last; a++) begin
      conv_addr        = 8'(a);
      conv_pixel_valid = (a >= first_valid);
      start            = poke_start && (a == 1);
      tick;
    end
    conv_addr        = '0;
    conv_pixel_valid = 1'b0;
    start            = 1'b0;
  endtask

  task automatic fc_group;
    repeat (2) tick;
    fc_valid = 1'b1;
    tick;
    fc_valid = 1'b0;
  endtask

  // Drive the sequencer up to the first FC_RUN cycle.
  task automatic run_to_fc;
    push_run();
    pulse_start();
    wload();
    conv_pass(CONV1_LAST, 0, 1'b0);
    for (int c = 0; c < CHAN; c++) begin
      wload();
      conv_pass(CONV2_LAST, 1, 1'b0);
    end
    wload();
  endtask

  task automatic full_run(input bit poke);
    int t0, c2, s0, p0, fs, fn, d0, s1;
    t0 = n_trig; c2 = n_trig_c2; s0 = n_save; p0 = n_pclr;
    fs = n_fcs; fn = n_fcn; d0 = n_done;
    push_run();
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_state", state_o, 1);
    chk("start_psum_clear", psum_clear, 1);
    wload();
    s1 = n_save;
    conv_pass(CONV1_LAST, 0, 1'b0);
    chk("c1_no_save", n_save - s1, 0);
    for (int c = 0; c < CHAN; c++) begin
      wload();
      conv_pass(CONV2_LAST, 1, poke && c == 0);
    end
    for (int g = 0; g < FC1_GROUPS; g++) begin
      wload();
      fc_group();
    end
    tick;
    chk("fc_finish_state", state_o, 9);
    chk("no_early_done", done, 0);
    fc_done = 1'b1;
    tick;
    fc_done = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    tick;
    chk("done_clear", done, 0);
    chk("back_idle", state_o, 0);
    chk("sb_drained", exp_q.size(), 0);
    chk("cnt_trigger", n_trig - t0, 3);
    chk("cnt_trigger_c2", n_trig_c2 - c2, 2);
    chk("cnt_psum_save", n_save - s0, 8);
    chk("cnt_psum_clear", n_pclr - p0, 1);
    chk("cnt_fc_start", n_fcs - fs, 1);
    chk("cnt_fc_next", n_fcn - fn, 2);
    chk("cnt_done", n_done - d0, 1);
  endtask

  initial begin
    int d0;
    // Reset state
    tick;
    chk("reset_outs", all_outs(), 0);
    rst_ni = 1'b1;
    tick;
    chk("post_reset_state", state_o, 0);
    chk("post_reset_busy", busy, 0);

    // Two clean runs; the second pokes start during C2_RUN
    full_run(1'b0);
    full_run(1'b1);

    // Abort in FC_RUN
    d0 = n_done;
    run_to_fc();
    chk("in_fc_run", state_o, 8);
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_state", state_o, 0);
    chk("abort_busy", busy, 0);
    chk("abort_conv_clear", conv_clear, 1);
    chk("abort_wreq", w_req, 0);
    chk("abort_layer", conv_layer, 0);
    tick;
    chk("abort_clear_pulse", conv_clear, 0);
    chk("abort_no_done", n_done - d0, 0);
    exp_q.delete();
    full_run(1'b0);

    // Asynchronous reset mid FC_RUN
    run_to_fc();
    chk("pre_reset_busy", busy, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset_outs", all_outs(), 0);
    tick;
    rst_ni = 1'b1;
    tick;
    chk("reset_release_state", state_o, 0);
    exp_q.delete();

    // Request never acknowledged
    pulse_start();
`ifdef SEQ_TIMEOUT_EN
    repeat (15) tick;
    chk("wd_not_yet", state_o, 1);
    tick;
    chk("wd_err_state", state_o, 11);
    chk("wd_err_flag", err, 1);
    chk("wd_err_busy", busy, 0);
    chk("wd_err_wreq", w_req, 0);
    chk("wd_err_clear", conv_clear, 1);
    pulse_start();
    chk("err_restart_state", state_o, 1);
    chk("err_restart_flag", err, 0);
`else
    repeat (100) tick;
    chk("no_wd_state", state_o, 1);
    chk("no_wd_wreq", w_req, 1);
    chk("no_wd_err", err, 0);
`endif
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("final_idle", state_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
